pwm_multichannel: RTL and testbench
===================================

Name: pwm_multichannel

Overview:
Multi-channel PWM generator and parametrised successor to the single-channel PWM path. A shared prescaler divides clk by a base divisor right-shifted by a frequency select. A shared period counter drives CHANNELS independent duty comparators. Duty and frequency updates taken while running are double-buffered and applied only at a period boundary, so outputs never glitch. The block sits between the control/register interface and the output pins.

Parameters:
CHANNELS, 4, number of PWM outputs
DUTY_WIDTH, 8, duty and period-counter width; one period = 2^DUTY_WIDTH prescaler ticks
FREQ_SEL_WIDTH, 2, width of frequency select
DIV_WIDTH, 32, prescaler counter width
BASE_DIV, 16, clocks per tick at freq_sel=0

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  pulse; load duty_in/freq_sel and run, or queue an update if already running
stop  input  1  pulse; halt immediately
duty_in  input  CHANNELS*DUTY_WIDTH  per-channel duty; channel i at bits [i*DUTY_WIDTH +: DUTY_WIDTH]
freq_sel  input  FREQ_SEL_WIDTH  tick divisor = BASE_DIV >> freq_sel
pwm_out  output  CHANNELS  registered PWM outputs
period_end  output  1  one-cycle pulse at each period wrap
busy  output  1  high in RUN
update_pending  output  1  shadow update queued, not yet applied

Behaviour:
- Reset is synchronous and active-low: when reset==0 at a clk edge:
  - state=IDLE
  - pwm_out=0, period_end=0, busy=0, update_pending=0
  - prescaler=0, counter=0
  - active and shadow duty/freq registers=0
- Effective divisor: div = BASE_DIV >> active_freq. If the result is 0, use 1. No other saturation.
- Prescaler: in RUN, counts 0..div-1. tick=1 on the cycle where prescaler==div-1, then prescaler wraps to 0.
- Counter: on tick, counter increments modulo 2^DUTY_WIDTH.
- Period length: div * 2^DUTY_WIDTH clk cycles.
- State IDLE:
  - start=1 (and stop=0): capture duty_in and freq_sel directly into the active registers; prescaler=0, counter=0; go to RUN. busy=1 from the next cycle.
  - stop alone: no effect.
- State RUN:
  - start=1: capture into the shadow registers; update_pending=1. A later start before the boundary overwrites the shadow (last write wins).
  - Boundary = tick while counter==2^DUTY_WIDTH-1. On that edge:
    - counter goes to 0.
    - period_end=1 for exactly one cycle.
    - if update_pending: copy shadow to active, clear update_pending, prescaler restarts at 0 using the new divisor.
  - start on the same cycle as the boundary: the newly captured values are stored to shadow and stay pending for the following boundary. The old shadow is applied.
  - stop=1: go to IDLE next edge; pwm_out=0, counter=0, prescaler=0, update_pending cleared, busy=0. Active registers are retained.
  - start and stop together: stop wins; the start is discarded.
- Output:
  - pwm_out[i] is registered: pwm_out[i] <= (state==RUN) && (counter < active_duty[i]).
  - One-cycle latency from counter to pin.
  - duty=0: constantly low.
  - duty=2^DUTY_WIDTH-1: low for exactly 1 tick per period.
  - High time = duty*div clocks per period.
- First period after start: pwm_out[i] rises one clk after busy rises when duty>0.
- Reset asserted mid-period overrides everything; no partial period completes.

Test Plan:
- Params CHANNELS=4, DUTY_WIDTH=4, BASE_DIV=4. start with freq_sel=0, duties {0,4,8,15} -> period 64 clks; high times {0,16,32,60} clks per period; period_end every 64 clks; busy=1.
- freq_sel=2 (div=1), duty ch1=8 -> period 16 clks, ch1 high 8 clks. freq_sel=3 (div 0 clamped to 1) -> identical waveform.
- In RUN, start with ch2 duty 8->2 mid-period -> update_pending=1. Current period keeps 32-clk high. From the clk after period_end, ch2 high 8 clks; update_pending=0.
- Two starts in one period (duty 3, then 12) -> only 12 applied at the boundary. Start coincident with boundary -> applied one period later.
- stop mid-period -> next edge pwm_out=0, busy=0. start and stop in the same cycle while IDLE -> stays IDLE.
- reset=0 mid-period with update_pending=1 -> all outputs 0 and update_pending=0 after the edge. A subsequent start runs from counter 0 with the new values.

Source files
------------

// File: rtl/pwm_multichannel_if.sv
// rtl/pwm_multichannel_if.sv - control and output bundle for the multi-channel PWM block
interface pwm_multichannel_if #(
  parameter int CHANNELS       = 4,
  parameter int DUTY_WIDTH     = 8,
  parameter int FREQ_SEL_WIDTH = 2
);
  logic                           start;
  logic                           stop;
  logic [CHANNELS*DUTY_WIDTH-1:0] duty_in;
  logic [FREQ_SEL_WIDTH-1:0]      freq_sel;
  logic [CHANNELS-1:0]            pwm_out;
  logic                           period_end;
  logic                           busy;
  logic                           update_pending;

  modport master (
    output start, stop, duty_in, freq_sel,
    input  pwm_out, period_end, busy, update_pending
  );

  modport slave (
    input  start, stop, duty_in, freq_sel,
    output pwm_out, period_end, busy, update_pending
  );
endinterface

// File: rtl/pwm_multichannel.sv
// rtl/pwm_multichannel.sv - shared prescaler/period counter driving CHANNELS duty comparators
module pwm_multichannel #(
  parameter int CHANNELS       = 4,
  parameter int DUTY_WIDTH     = 8,
  parameter int FREQ_SEL_WIDTH = 2,
  parameter int DIV_WIDTH      = 32,
  parameter int BASE_DIV       = 16
) (
  input  logic                clk,
  input  logic                reset,
  pwm_multichannel_if.slave   bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_WIDTH-1:0] BASE = DIV_WIDTH'(BASE_DIV);

  state_t                         state, state_next;
  logic [DIV_WIDTH-1:0]           prescaler, div;
  logic [DUTY_WIDTH-1:0]          counter;
  logic [CHANNELS*DUTY_WIDTH-1:0] active_duty, shadow_duty;
  logic [FREQ_SEL_WIDTH-1:0]      active_freq, shadow_freq;
  logic                           pending;
  logic [CHANNELS-1:0]            pwm_q, duty_hit;
  logic                           period_end_q;
  logic                           tick, boundary;

  // A divisor shifted down to zero would never tick, so it is clamped to one.
  always_comb begin
    div = BASE >> active_freq;
    if (div == '0) div = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  end

  assign tick     = (state == RUN) && (prescaler == div - 1'b1);
  assign boundary = tick && (counter == '1);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      duty_hit[i] = counter < active_duty[i*DUTY_WIDTH +: DUTY_WIDTH];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start && !bus.stop) state_next = RUN;
      RUN:  if (bus.stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      prescaler    <= '0;
      counter      <= '0;
      active_duty  <= '0;
      shadow_duty  <= '0;
      active_freq  <= '0;
      shadow_freq  <= '0;
      pending      <= 1'b0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
    end else begin
      state        <= state_next;
      period_end_q <= 1'b0;
      pwm_q        <= '0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            active_duty <= bus.duty_in;
            active_freq <= bus.freq_sel;
            prescaler   <= '0;
            counter     <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            prescaler <= '0;
            counter   <= '0;
            pending   <= 1'b0;
          end else begin
            pwm_q <= duty_hit;
            if (tick) begin
              prescaler <= '0;
              counter   <= counter + 1'b1;
            end else begin
              prescaler <= prescaler + 1'b1;
            end
            if (boundary) begin
              period_end_q <= 1'b1;
              if (pending) begin
                active_duty <= shadow_duty;
                active_freq <= shadow_freq;
                pending     <= 1'b0;
              end
            end
            // A start on the boundary edge lands in the shadow and waits a full period.
            if (bus.start) begin
              shadow_duty <= bus.duty_in;
              shadow_freq <= bus.freq_sel;
              pending     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pwm_out        = pwm_q;
  assign bus.period_end     = period_end_q;
  assign bus.busy           = (state == RUN);
  assign bus.update_pending = pending;
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb/tb_pwm_multichannel.sv - randomized and directed checks against a period-position model
module tb_pwm_multichannel;
  localparam int CH   = 4;
  localparam int DW   = 4;
  localparam int FW   = 2;
  localparam int BASE = 4;
  localparam int STEPS_PER_PERIOD = 1 << DW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pwm_multichannel_if #(.CHANNELS(CH), .DUTY_WIDTH(DW), .FREQ_SEL_WIDTH(FW)) bus ();

  pwm_multichannel #(
    .CHANNELS(CH), .DUTY_WIDTH(DW), .FREQ_SEL_WIDTH(FW), .DIV_WIDTH(8), .BASE_DIV(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model tracks the clock position inside the current period rather than prescaler/counter.
  bit           m_run, m_pend, m_pe;
  int           m_pos, m_af, m_sf;
  int           m_ad[CH], m_sd[CH];
  logic [CH-1:0] m_pwm;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_div(input int f);
    int d;
    d = BASE >> f;
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_update(input bit st, input bit sp, input bit rs);
    int d;
    if (!rs) begin
      m_run = 0; m_pend = 0; m_pe = 0; m_pos = 0; m_af = 0; m_sf = 0; m_pwm = '0;
      for (int i = 0; i < CH; i++) begin m_ad[i] = 0; m_sd[i] = 0; end
    end else if (!m_run) begin
      m_pwm = '0; m_pe = 0;
      if (st && !sp) begin
        for (int i = 0; i < CH; i++) m_ad[i] = int'(bus.duty_in[i*DW +: DW]);
        m_af = int'(bus.freq_sel); m_run = 1; m_pos = 0;
      end
    end else if (sp) begin
      m_run = 0; m_pos = 0; m_pend = 0; m_pwm = '0; m_pe = 0;
    end else begin
      d = model_div(m_af);
      for (int i = 0; i < CH; i++) m_pwm[i] = (m_pos < m_ad[i] * d);
      m_pe = (m_pos == d * STEPS_PER_PERIOD - 1);
      if (m_pe) begin
        m_pos = 0;
        if (m_pend) begin
          m_ad = m_sd; m_af = m_sf; m_pend = 0;
        end
      end else begin
        m_pos++;
      end
      if (st) begin
        for (int i = 0; i < CH; i++) m_sd[i] = int'(bus.duty_in[i*DW +: DW]);
        m_sf = int'(bus.freq_sel); m_pend = 1;
      end
    end
  endtask

  task automatic step(input bit st, input bit sp, input bit rs);
    bus.start = st; bus.stop = sp; reset = rs;
    @(posedge clk);
    model_update(st, sp, rs);
    #1;
    check_eq("pwm_out", 32'(bus.pwm_out), 32'(m_pwm));
    check_eq("period_end", 32'(bus.period_end), 32'(m_pe));
    check_eq("busy", 32'(bus.busy), 32'(m_run));
    check_eq("update_pending", 32'(bus.update_pending), 32'(m_pend));
    bus.start = 1'b0; bus.stop = 1'b0; reset = 1'b1;
  endtask

  task automatic set_cfg(input logic [CH*DW-1:0] d, input logic [FW-1:0] f);
    bus.duty_in = d; bus.freq_sel = f;
  endtask

  int hi[CH];
  int n_pe;
  int guard;

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.duty_in = '0; bus.freq_sel = '0;
    model_update(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("rst_pwm", 32'(bus.pwm_out), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_pend", 32'(bus.update_pending), 32'h0);

    // Four duties at div 4: one 64-clock period, high times 0/16/32/60.
    set_cfg({4'd15, 4'd8, 4'd4, 4'd0}, 2'd0);
    step(1, 0, 1);
    check_eq("start_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    n_pe = 0;
    for (int k = 0; k < 128; k++) begin
      step(0, 0, 1);
      if (k < 64) for (int i = 0; i < CH; i++) hi[i] += int'(bus.pwm_out[i]);
      n_pe += int'(bus.period_end);
    end
    check_eq("hi_ch0", hi[0], 0);
    check_eq("hi_ch1", hi[1], 16);
    check_eq("hi_ch2", hi[2], 32);
    check_eq("hi_ch3", hi[3], 60);
    check_eq("pe_count", n_pe, 2);

    // freq_sel 2 and 3 both give div 1.
    for (int f = 2; f <= 3; f++) begin
      step(0, 1, 1);
      set_cfg({4'd0, 4'd0, 4'd8, 4'd0}, FW'(f));
      step(1, 0, 1);
      hi[1] = 0;
      for (int k = 0; k < 16; k++) begin step(0, 0, 1); hi[1] += int'(bus.pwm_out[1]); end
      check_eq("hi_div1", hi[1], 8);
    end

    // Mid-period update ch2 8 -> 2, applied after the boundary.
    step(0, 1, 1);
    set_cfg({4'd15, 4'd8, 4'd4, 4'd0}, 2'd0);
    step(1, 0, 1);
    repeat (20) step(0, 0, 1);
    set_cfg({4'd15, 4'd2, 4'd4, 4'd0}, 2'd0);
    step(1, 0, 1);
    check_eq("upd_pending", 32'(bus.update_pending), 32'h1);
    guard = 0;
    while (!bus.period_end && guard < 200) begin step(0, 0, 1); guard++; end
    check_eq("pe_timeout", 32'(guard < 200), 32'h1);
    hi[2] = 0;
    for (int k = 0; k < 64; k++) begin step(0, 0, 1); hi[2] += int'(bus.pwm_out[2]); end
    check_eq("hi_upd_ch2", hi[2], 8);
    check_eq("upd_cleared", 32'(bus.update_pending), 32'h0);

    // Two starts in one period, then a start on the boundary edge.
    set_cfg({4'd3, 4'd3, 4'd3, 4'd3}, 2'd0);
    step(1, 0, 1);
    repeat (5) step(0, 0, 1);
    set_cfg({4'd12, 4'd12, 4'd12, 4'd12}, 2'd0);
    step(1, 0, 1);
    repeat (80) step(0, 0, 1);
    guard = 0;
    while (m_pos != model_div(m_af) * STEPS_PER_PERIOD - 1 && guard < 200) begin step(0, 0, 1); guard++; end
    set_cfg({4'd1, 4'd5, 4'd9, 4'd14}, 2'd1);
    step(1, 0, 1);
    check_eq("coinc_pending", 32'(bus.update_pending), 32'h1);
    repeat (150) step(0, 0, 1);

    // Stop mid-period, then start+stop while idle.
    step(0, 1, 1);
    check_eq("stop_busy", 32'(bus.busy), 32'h0);
    check_eq("stop_pwm", 32'(bus.pwm_out), 32'h0);
    step(1, 1, 1);
    check_eq("idle_ss_busy", 32'(bus.busy), 32'h0);

    // Reset mid-period with an update queued.
    set_cfg({4'd15, 4'd8, 4'd4, 4'd2}, 2'd0);
    step(1, 0, 1);
    repeat (10) step(0, 0, 1);
    set_cfg({4'd6, 4'd6, 4'd6, 4'd6}, 2'd1);
    step(1, 0, 1);
    repeat (3) step(0, 0, 1);
    step(0, 0, 0);
    check_eq("rst_mid_pend", 32'(bus.update_pending), 32'h0);
    check_eq("rst_mid_pwm", 32'(bus.pwm_out), 32'h0);
    check_eq("rst_mid_busy", 32'(bus.busy), 32'h0);
    set_cfg({4'd7, 4'd3, 4'd11, 4'd0}, 2'd1);
    step(1, 0, 1);
    repeat (70) step(0, 0, 1);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      bit st, sp, rs;
      set_cfg(CH*DW'($urandom), FW'($urandom));
      st = m_run ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 249) == 0);
      rs = !($urandom_range(0, 999) == 0);
      step(st, sp, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
